// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART word layout constants and echo output FSM state type
package uart_pkg;

  localparam int UART_WORD_WIDTH    = 10;
  localparam int UART_DATA_WIDTH    = 8;
  localparam int UART_WORD_ERR_BIT  = 8;
  localparam int UART_WORD_STOP_BIT = 9;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } echo_state_t;

endpackage

// File: rtl/echo_buf.sv
// rtl/echo_buf.sv - circular byte buffer with wrap-bit pointers, show-ahead read
module echo_buf #(
  parameter int BUF_DEPTH      = 4,
  parameter int BUF_ADDR_WIDTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  logic [7:0]              mem [BUF_DEPTH];
  logic [BUF_ADDR_WIDTH:0] wr_ptr;
  logic [BUF_ADDR_WIDTH:0] rd_ptr;

  // Same slot but opposite lap means the writer is a full lap ahead.
  assign full  = (wr_ptr[BUF_ADDR_WIDTH-1:0] == rd_ptr[BUF_ADDR_WIDTH-1:0]) &&
                 (wr_ptr[BUF_ADDR_WIDTH] != rd_ptr[BUF_ADDR_WIDTH]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[BUF_ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[BUF_ADDR_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_echo_responder.sv
// rtl/uart_echo_responder.sv - echoes good UART receive words back to uart_tx; optional UART_ECHO_STATS_EN counters
module uart_echo_responder
  import uart_pkg::*;
#(
  parameter int BUF_DEPTH      = 4,
  parameter int BUF_ADDR_WIDTH = 2
) (
  input  logic                       pclk_i,
  input  logic                       prst_n_i,
  input  logic [UART_WORD_WIDTH-1:0] rd_data_i,
  input  logic                       rd_data_valid_i,
  output logic                       rd_ready_o,
  output logic [UART_DATA_WIDTH-1:0] tx_pdata_o,
  output logic                       tx_pdata_valid_o,
  input  logic                       tx_pready_i
`ifdef UART_ECHO_STATS_EN
  ,
  output logic [15:0]                rx_count_o,
  output logic [15:0]                err_count_o,
  output logic [15:0]                tx_count_o
`endif
);

  echo_state_t                state, next_state;
  logic                       accept, good, push, pop;
  logic                       buf_full, buf_empty;
  logic [UART_DATA_WIDTH-1:0] buf_rdata;

  assign rd_ready_o       = !buf_full;
  assign accept           = rd_data_valid_i && rd_ready_o;
  assign good             = !rd_data_i[UART_WORD_ERR_BIT] && rd_data_i[UART_WORD_STOP_BIT];
  assign push             = accept && good;
  assign tx_pdata_valid_o = (state == HOLD);

  echo_buf #(
    .BUF_DEPTH      (BUF_DEPTH),
    .BUF_ADDR_WIDTH (BUF_ADDR_WIDTH)
  ) u_echo_buf (
    .clk   (pclk_i),
    .rst_n (prst_n_i),
    .push  (push),
    .pop   (pop),
    .wdata (rd_data_i[UART_DATA_WIDTH-1:0]),
    .rdata (buf_rdata),
    .full  (buf_full),
    .empty (buf_empty)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      EMPTY: begin
        if (!buf_empty) begin
          pop        = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (tx_pready_i) begin
          if (!buf_empty) pop = 1'b1;
          else            next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      state      <= EMPTY;
      tx_pdata_o <= '0;
    end else begin
      state <= next_state;
      if (pop) tx_pdata_o <= buf_rdata;
    end
  end

`ifdef UART_ECHO_STATS_EN
  always_ff @(posedge pclk_i or negedge prst_n_i) begin
    if (!prst_n_i) begin
      rx_count_o  <= '0;
      err_count_o <= '0;
      tx_count_o  <= '0;
    end else begin
      if (accept)          rx_count_o  <= rx_count_o + 16'd1;
      if (accept && !good) err_count_o <= err_count_o + 16'd1;
      if (tx_pdata_valid_o && tx_pready_i) tx_count_o <= tx_count_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_echo_responder.sv
// tb/tb_uart_echo_responder.sv - scoreboard bench for uart_echo_responder (counter checks when UART_ECHO_STATS_EN)
module tb_uart_echo_responder;

  logic       pclk_i = 1'b0;
  logic       prst_n_i;
  logic [9:0] rd_data_i;
  logic       rd_data_valid_i;
  logic       rd_ready_o;
  logic [7:0] tx_pdata_o;
  logic       tx_pdata_valid_o;
  logic       tx_pready_i;
`ifdef UART_ECHO_STATS_EN
  logic [15:0] rx_count_o, err_count_o, tx_count_o;
`endif

  int compared   = 0;
  int mismatched = 0;
  int ready_mode = 1;  // 0 low, 1 high, 2 random, 3 driven by the test
  logic [7:0] exp_q[$];
  int rx_model = 0, err_model = 0, tx_model = 0;
  logic hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  uart_echo_responder dut (
    .pclk_i           (pclk_i),
    .prst_n_i         (prst_n_i),
    .rd_data_i        (rd_data_i),
    .rd_data_valid_i  (rd_data_valid_i),
    .rd_ready_o       (rd_ready_o),
    .tx_pdata_o       (tx_pdata_o),
    .tx_pdata_valid_o (tx_pdata_valid_o),
    .tx_pready_i      (tx_pready_i)
`ifdef UART_ECHO_STATS_EN
    ,
    .rx_count_o       (rx_count_o),
    .err_count_o      (err_count_o),
    .tx_count_o       (tx_count_o)
`endif
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge pclk_i) begin
    #1;
    case (ready_mode)
      0: tx_pready_i = 1'b0;
      1: tx_pready_i = 1'b1;
      2: tx_pready_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Monitor: the transfer that will happen at the next posedge is visible at this negedge.
  always @(negedge pclk_i) begin
    if (prst_n_i) begin
      if (hold_prev) begin
        check("hold_valid", 32'(tx_pdata_valid_o), 32'd1);
        check("hold_data", 32'(tx_pdata_o), 32'(hold_data));
      end
      if (tx_pdata_valid_o && tx_pready_i) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_tx: got 0x%0h, expected no output", tx_pdata_o);
        end else begin
          check("tx_byte", 32'(tx_pdata_o), 32'(exp_q.pop_front()));
        end
        tx_model++;
      end
      hold_prev = tx_pdata_valid_o && !tx_pready_i;
      hold_data = tx_pdata_o;
    end
  end

  task automatic set_mode(input int m);
    ready_mode = m;
    if (m == 0) tx_pready_i = 1'b0;
    if (m == 1) tx_pready_i = 1'b1;
  endtask

  // Present one word until the DUT accepts it; the good ones become expected echoes.
  task automatic send(input logic [9:0] w, output int waited);
    bit acc = 0;
    waited = 0;
    rd_data_i = w;
    rd_data_valid_i = 1'b1;
    while (!acc && waited < 300) begin
      @(negedge pclk_i);
      if (rd_ready_o) acc = 1;
      @(posedge pclk_i);
      #1;
      waited++;
    end
    rd_data_valid_i = 1'b0;
    if (!acc) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no accept, expected accept of 0x%0h", w);
    end else begin
      rx_model++;
      if (w[8] == 1'b0 && w[9] == 1'b1) exp_q.push_back(w[7:0]);
      else err_model++;
    end
  endtask

  task automatic drain(output int cycles);
    cycles = 0;
    while ((exp_q.size() != 0 || tx_pdata_valid_o) && cycles < 500) begin
      @(posedge pclk_i);
      #1;
      cycles++;
    end
    if (cycles >= 500) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d bytes pending, expected 0", exp_q.size());
    end
  endtask

  task automatic check_counts(input string tag);
`ifdef UART_ECHO_STATS_EN
    check({tag, "_rx_count"}, 32'(rx_count_o), 32'(rx_model & 16'hFFFF));
    check({tag, "_err_count"}, 32'(err_count_o), 32'(err_model & 16'hFFFF));
    check({tag, "_tx_count"}, 32'(tx_count_o), 32'(tx_model & 16'hFFFF));
`endif
  endtask

  initial begin
    int w, cyc;
    logic [9:0] word;
    prst_n_i = 1'b0;
    rd_data_i = '0;
    rd_data_valid_i = 1'b0;
    tx_pready_i = 1'b1;
    repeat (2) @(posedge pclk_i);
    @(negedge pclk_i);
    prst_n_i = 1'b1;
    #1;
    check("reset_valid", 32'(tx_pdata_valid_o), 32'd0);
    check("reset_data", 32'(tx_pdata_o), 32'h00);
    check("reset_ready", 32'(rd_ready_o), 32'd1);
    check_counts("reset");
    @(posedge pclk_i);
    #1;

    // Single good word and its latency.
    set_mode(1);
    send(10'b10_0100_0001, w);
    check("lat_valid_k", 32'(tx_pdata_valid_o), 32'd0);
    @(posedge pclk_i);
    #1;
    check("lat_valid_k1", 32'(tx_pdata_valid_o), 32'd1);
    check("lat_data_k1", 32'(tx_pdata_o), 32'h41);
    drain(cyc);
    check_counts("single");

    // Bad words are dropped.
    send(10'h141, w);
    send(10'h041, w);
    repeat (3) begin
      @(posedge pclk_i);
      #1;
      check("bad_no_valid", 32'(tx_pdata_valid_o), 32'd0);
    end
    check_counts("bad");

    // Back-pressure: one byte in HOLD plus a full buffer, sixth word waits.
    set_mode(0);
    for (int i = 1; i <= 5; i++) send({2'b10, 8'(i)}, w);
    rd_data_i = 10'h206;
    rd_data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk_i);
      check("bp_ready_low", 32'(rd_ready_o), 32'd0);
      @(posedge pclk_i);
      #1;
    end
    check("bp_hold_valid", 32'(tx_pdata_valid_o), 32'd1);
    check("bp_hold_data", 32'(tx_pdata_o), 32'h01);
    set_mode(1);
    send(10'h206, w);
    drain(cyc);
    check("bp_drain_rate", 32'(cyc <= 8), 32'd1);
    check_counts("bp");

    // Wrap-around with random ready and interleaved bad words.
    set_mode(2);
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        word = {1'($urandom_range(0, 1)), 1'b1, 8'($urandom)};
        if (word[9]) word[8] = 1'b1;
        send(word, w);
      end
      send({2'b10, 8'(8'h10 + i)}, w);
    end
    for (int i = 0; i < 30; i++) begin
      send(10'($urandom), w);
      repeat ($urandom_range(0, 2)) @(posedge pclk_i);
      #1;
    end
    set_mode(1);
    drain(cyc);
    check_counts("rand");

    // Full buffer with simultaneous pop and offered word.
    set_mode(3);
    tx_pready_i = 1'b0;
    for (int i = 0; i < 5; i++) send({2'b10, 8'(8'h30 + i)}, w);
    rd_data_i = 10'h235;
    rd_data_valid_i = 1'b1;
    tx_pready_i = 1'b1;
    @(negedge pclk_i);
    check("full_ready_low", 32'(rd_ready_o), 32'd0);
    @(posedge pclk_i);
    #1;
    tx_pready_i = 1'b0;
    send(10'h235, w);
    check("full_push_next", 32'(w), 32'd1);
    set_mode(1);
    drain(cyc);
    check_counts("full");

    // Reset mid-stream: HOLD active with three buffered bytes.
    set_mode(0);
    for (int i = 0; i < 4; i++) send({2'b10, 8'(8'h50 + i)}, w);
    @(negedge pclk_i);
    #2;
    prst_n_i = 1'b0;
    #1;
    check("rst_mid_valid", 32'(tx_pdata_valid_o), 32'd0);
    check("rst_mid_data", 32'(tx_pdata_o), 32'h00);
    check("rst_mid_ready", 32'(rd_ready_o), 32'd1);
    exp_q.delete();
    hold_prev = 1'b0;
    rx_model = 0;
    err_model = 0;
    tx_model = 0;
    #1;
    prst_n_i = 1'b1;
    set_mode(1);
    repeat (10) @(posedge pclk_i);
    #1;
    check("rst_quiet", 32'(tx_pdata_valid_o), 32'd0);
    send(10'h27E, w);
    drain(cyc);
    check_counts("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
